dmem_arb: RTL and testbench
===========================

Name: dmem_arb

Overview:
- Single-port data-memory arbiter for the 16-bit accumulator pipeline.
- Shares one synchronous-read data memory between three requesters: the ID-stage operand fetch (direct or indirect addressing), the accumulator store writeback, and a host/debug load port.
- Sequences the two-access indirect fetch (pointer read, then operand read).
- Drives a stall to the pipeline while an operand is outstanding.

Parameters:
- AW, 10, address width.
- DW, 16, data width.
- DEPTH, 623, data-memory words; valid addresses are 0..DEPTH-1.
- HOST_MAXWAIT, 8, consecutive ungranted host-request cycles before the host is promoted to top priority.

Ports:
- clk1  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- of_req  in  1  operand fetch request.
- of_ind  in  1  1 = indirect: operand address is mem[of_addr].
- of_addr  in  AW  fetch address.
- of_gnt  out  1  fetch accepted (pulse).
- of_valid  out  1  fetch data valid (pulse).
- of_rdata  out  DW  fetch data; 0 when of_err.
- of_err  out  1  out-of-range address on the fetch; qualifies of_valid.
- st_req  in  1  store request.
- st_addr  in  AW  store address.
- st_wdata  in  DW  store data.
- st_gnt  out  1  store accepted and written this cycle.
- hs_req  in  1  host request.
- hs_we  in  1  host write enable.
- hs_addr  in  AW  host address.
- hs_wdata  in  DW  host write data.
- hs_gnt  out  1  host accepted.
- hs_valid  out  1  host read data valid.
- hs_rdata  out  DW  host read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after a read.
- stall  out  1  = (of_req & ~of_gnt) | indirect in flight | fetch response pending.

Behaviour:
- Reset (rst=0, async): state IDLE, host wait counter 0, response flags cleared; every output 0. Reset mid-indirect abandons the transaction; no of_valid is issued afterwards.
- Handshake: a requester holds req and its address/data stable until gnt. gnt is a one-cycle pulse; the memory access is issued combinationally in the grant cycle (mem_* driven from the winning port).
- Read latency: grant in cycle N; *_valid and *_rdata = mem_rdata in N+1 (combinational pass-through). Writes complete at the end of cycle N; there is no further response.
- Throughput: one grant per cycle in IDLE, so back-to-back accesses are allowed.
- Priority in IDLE:
  1. Host, if its wait counter == HOST_MAXWAIT.
  2. Store.
  3. Fetch.
  4. Host.
- Wait counter: increments each cycle hs_req=1 & hs_gnt=0, saturates at HOST_MAXWAIT, clears on hs_gnt or when hs_req=0.
- FSM:
  - IDLE → IND2 on grant of a fetch with of_ind=1.
  - IND2 (cycle N+1): pointer = mem_rdata[AW-1:0]; issue operand read at pointer; no other grant this cycle. Returns to IDLE.
  - Indirect fetch: of_valid in N+2.
- Address check: any address ≥ DEPTH (request or pointer) suppresses mem_en. The response still arrives on schedule with rdata=0, and of_err=1 for fetches. An out-of-range host write is dropped silently; hs_gnt is still pulsed.
- Ordering: a store and a fetch to the same address in the same cycle → the store wins; the fetch is granted next cycle and reads the new value. This read-after-write guarantee comes from the single port.
- Simultaneous st_req/of_req/hs_req with the counter saturated → the host wins. The store is granted next cycle, then the fetch.
- of_ind is sampled only at grant. Changes to a request's inputs after its grant are ignored.

Decomposition:
- Package dmem_pkg:
  - AW/DW/DEPTH defaults.
  - FSM state encoding (IDLE, IND2).
  - Port-select constants (SEL_NONE, SEL_ST, SEL_OF, SEL_HS).
  - in_range(addr) function.
- One sub-module, arb_prio_sel: combinational fixed-priority selector with a host-override input, returning a SEL_* code. The FSM, wait counter and memory mux stay in dmem_arb.

Test Plan:
- Mem preloaded mem[5]=0x1234; of_req, of_ind=0, of_addr=5 → of_gnt in cycle N; of_valid & of_rdata=0x1234 in N+1; stall high until N+1.
- mem[7]=20, mem[20]=0xBEEF; indirect fetch of 7 → of_valid in N+2 with 0xBEEF; no other gnt in N+1 even with st_req held.
- st_req addr 9 data 0x00AA together with of_req addr 9 (old 0x0011) → st_gnt N, of_gnt N+1, of_rdata 0x00AA in N+2.
- hs_req held while st_req/of_req alternate continuously → hs_gnt by cycle 9 at the latest (counter hits 8), then the counter reads 0.
- of_addr=700 → no mem_en; of_valid N+1 with of_err=1, of_rdata=0. Indirect pointer mem[3]=650 → of_err at N+2.
- rst low during IND2 → all outputs 0 immediately; after release, no stray of_valid; the next direct fetch completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared widths, FSM encoding and port-select codes for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned AW           = 10;
    localparam int unsigned DW           = 16;
    localparam int unsigned DEPTH        = 623;
    localparam int unsigned HOST_MAXWAIT = 8;
    localparam int unsigned CW           = $clog2(HOST_MAXWAIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        IND2 = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ST   = 2'd1,
        SEL_OF   = 2'd2,
        SEL_HS   = 2'd3
    } sel_t;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < DEPTH;
    endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed-priority port selector: starved host, then store, fetch, host.
module arb_prio_sel
    import dmem_pkg::*;
(
    input  logic en,
    input  logic host_ovr,
    input  logic st_req,
    input  logic of_req,
    input  logic hs_req,
    output sel_t sel_c
);

    always_comb begin
        sel_c = SEL_NONE;
        if (en) begin
            if (host_ovr && hs_req) sel_c = SEL_HS;
            else if (st_req)        sel_c = SEL_ST;
            else if (of_req)        sel_c = SEL_OF;
            else if (hs_req)        sel_c = SEL_HS;
        end
    end

endmodule

// File: rtl/dmem_arb.sv
// Single-port data-memory arbiter: store / operand fetch (direct or indirect) / host.
// Grants and the memory access are combinational; read data passes straight through.
module dmem_arb
    import dmem_pkg::*;
(
    input  logic          clk1,
    input  logic          rst,
    input  logic          of_req,
    input  logic          of_ind,
    input  logic [AW-1:0] of_addr,
    output logic          of_gnt,
    output logic          of_valid,
    output logic [DW-1:0] of_rdata,
    output logic          of_err,
    input  logic          st_req,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_wdata,
    output logic          st_gnt,
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    output logic          hs_gnt,
    output logic          hs_valid,
    output logic [DW-1:0] hs_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          of_pend_q, of_pend_d;
    logic          hs_pend_q, hs_pend_d;
    logic          err_q, err_d;
    logic          ind_bad_q, ind_bad_d;
    logic          host_ovr;
    logic [AW-1:0] ptr;
    sel_t          sel_c;

    assign host_ovr = (cnt_q == CW'(HOST_MAXWAIT));
    assign ptr      = mem_rdata[AW-1:0];

    arb_prio_sel u_sel (
        .en       (rst && (state_q == IDLE)),
        .host_ovr (host_ovr),
        .st_req   (st_req),
        .of_req   (of_req),
        .hs_req   (hs_req),
        .sel_c    (sel_c)
    );

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            of_pend_q <= 1'b0;
            hs_pend_q <= 1'b0;
            err_q     <= 1'b0;
            ind_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            of_pend_q <= of_pend_d;
            hs_pend_q <= hs_pend_d;
            err_q     <= err_d;
            ind_bad_q <= ind_bad_d;
        end
    end

    // Outputs are forced low while rst is asserted so reset acts on them immediately.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        of_pend_d = 1'b0;
        hs_pend_d = 1'b0;
        err_d     = 1'b0;
        ind_bad_d = ind_bad_q;
        of_gnt    = 1'b0;
        st_gnt    = 1'b0;
        hs_gnt    = 1'b0;
        of_valid  = 1'b0;
        of_err    = 1'b0;
        of_rdata  = '0;
        hs_valid  = 1'b0;
        hs_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;

        if (rst) begin
            of_valid = of_pend_q;
            of_err   = of_pend_q & err_q;
            of_rdata = (of_pend_q && !err_q) ? mem_rdata : '0;
            hs_valid = hs_pend_q;
            hs_rdata = (hs_pend_q && !err_q) ? mem_rdata : '0;

            case (state_q)
                IDLE: begin
                    case (sel_c)
                        SEL_ST: begin
                            st_gnt    = 1'b1;
                            mem_en    = in_range(st_addr);
                            mem_we    = mem_en;
                            mem_addr  = st_addr;
                            mem_wdata = st_wdata;
                        end
                        SEL_OF: begin
                            of_gnt   = 1'b1;
                            mem_en   = in_range(of_addr);
                            mem_addr = of_addr;
                            if (of_ind) begin
                                state_d   = IND2;
                                ind_bad_d = !in_range(of_addr);
                            end else begin
                                of_pend_d = 1'b1;
                                err_d     = !in_range(of_addr);
                            end
                        end
                        SEL_HS: begin
                            hs_gnt    = 1'b1;
                            mem_en    = in_range(hs_addr);
                            mem_we    = mem_en & hs_we;
                            mem_addr  = hs_addr;
                            mem_wdata = hs_wdata;
                            hs_pend_d = !hs_we;
                            err_d     = !hs_we && !in_range(hs_addr);
                        end
                        default: ;
                    endcase
                end
                IND2: begin
                    // Pointer arrives on mem_rdata; issue the operand read at it.
                    mem_en    = !ind_bad_q && in_range(ptr);
                    mem_addr  = ptr;
                    of_pend_d = 1'b1;
                    err_d     = ind_bad_q || !in_range(ptr);
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase

            stall = (of_req & ~of_gnt) | (state_q == IND2) | of_pend_q;

            if (hs_req && !hs_gnt) cnt_d = host_ovr ? cnt_q : cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: directed scenarios plus randomized traffic vs a reference model.
module tb_dmem_arb;
    import dmem_pkg::*;

    logic          clk1 = 1'b0;
    logic          rst  = 1'b0;
    logic          of_req = 1'b0, of_ind = 1'b0;
    logic [AW-1:0] of_addr = '0;
    logic          of_gnt, of_valid, of_err;
    logic [DW-1:0] of_rdata;
    logic          st_req = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_wdata = '0;
    logic          st_gnt;
    logic          hs_req = 1'b0, hs_we = 1'b0;
    logic [AW-1:0] hs_addr = '0;
    logic [DW-1:0] hs_wdata = '0;
    logic          hs_gnt, hs_valid;
    logic [DW-1:0] hs_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int nvec = 0;
    int errs = 0;

    always #5 clk1 = ~clk1;

    // Synchronous-read single-port RAM seen by the arbiter.
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    dmem_arb dut (
        .clk1(clk1), .rst(rst),
        .of_req(of_req), .of_ind(of_ind), .of_addr(of_addr), .of_gnt(of_gnt),
        .of_valid(of_valid), .of_rdata(of_rdata), .of_err(of_err),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_gnt(st_gnt),
        .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
        .hs_gnt(hs_gnt), .hs_valid(hs_valid), .hs_rdata(hs_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic smp();
        @(negedge clk1);
    endtask

    function automatic bit inr(input logic [AW-1:0] a);
        return int'(a) < int'(DEPTH);
    endfunction

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DEPTH, 1023));
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 15));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    // Bounded wait for a grant; returns at the sampling point of the grant cycle.
    task automatic wait_gnt(input int which, input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            smp();
            got = (which == 0) ? st_gnt : (which == 1) ? of_gnt : hs_gnt;
            if (!got) cyc();
        end
        nvec++;
        if (!got) begin
            errs++;
            $display("FAIL %s: no grant within 40 cycles (got 0, want 1)", name);
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = a; hs_wdata = d;
        wait_gnt(2, "host_write");
        if (inr(a)) ref_mem[a] = d;
        cyc();
        hs_req = 1'b0; hs_we = 1'b0;
    endtask

    task automatic test_reset();
        of_req = 1'b1; st_req = 1'b1; hs_req = 1'b1; of_addr = 10'd1; st_addr = 10'd2; hs_addr = 10'd3;
        smp();
        nvec++;
        if ({of_gnt, of_valid, of_err, st_gnt, hs_gnt, hs_valid, mem_en, mem_we, stall} !== 9'b0) begin
            errs++;
            $display("FAIL reset_ctl: got %b want 0", {of_gnt, of_valid, of_err, st_gnt, hs_gnt, hs_valid, mem_en, mem_we, stall});
        end
        nvec++;
        if ({of_rdata, hs_rdata, mem_addr, mem_wdata} !== '0) begin
            errs++;
            $display("FAIL reset_data: got %h want 0", {of_rdata, hs_rdata, mem_addr, mem_wdata});
        end
        of_req = 1'b0; st_req = 1'b0; hs_req = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        smp();
        nvec++;
        if ({of_gnt, of_valid, st_gnt, hs_gnt, hs_valid, mem_en, stall} !== 7'b0) begin
            errs++;
            $display("FAIL idle_after_reset: got %b want 0", {of_gnt, of_valid, st_gnt, hs_gnt, hs_valid, mem_en, stall});
        end
        cyc();
    endtask

    task automatic direct_fetch(input logic [AW-1:0] a, input string name);
        logic [DW-1:0] exp_d;
        exp_d = ref_mem[a];
        of_req = 1'b1; of_ind = 1'b0; of_addr = a;
        wait_gnt(1, name);
        cyc();
        of_req = 1'b0;
        smp();
        nvec++;
        if ({of_valid, of_err, stall, of_rdata} !== {3'b101, exp_d}) begin
            errs++;
            $display("FAIL %s: got v/e/stall/data %b%b%b/%h want 101/%h", name, of_valid, of_err, stall, of_rdata, exp_d);
        end
        cyc();
        smp();
        nvec++;
        if ({of_valid, stall} !== 2'b00) begin
            errs++;
            $display("FAIL %s_after: got valid/stall %b%b want 00", name, of_valid, stall);
        end
        cyc();
    endtask

    task automatic test_direct();
        host_write(10'd5, 16'h1234);
        direct_fetch(10'd5, "direct_5");
        for (int i = 0; i < 6; i++) direct_fetch(AW'($urandom_range(0, DEPTH - 1)), "direct_rand");
    endtask

    task automatic test_indirect();
        logic [DW-1:0] sd;
        host_write(10'd7, 16'd20);
        host_write(10'd20, 16'hBEEF);
        of_req = 1'b1; of_ind = 1'b1; of_addr = 10'd7;
        wait_gnt(1, "ind_gnt");
        cyc();
        sd = 16'($urandom);
        of_req = 1'b0; of_ind = 1'b0; st_req = 1'b1; st_addr = 10'd100; st_wdata = sd;
        smp();
        nvec++;
        if ({st_gnt, of_gnt, hs_gnt, of_valid, stall} !== 5'b00001) begin
            errs++;
            $display("FAIL ind_n1: got gnts/valid/stall %b want 00001", {st_gnt, of_gnt, hs_gnt, of_valid, stall});
        end
        nvec++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd20}) begin
            errs++;
            $display("FAIL ind_ptr_rd: got en/we/addr %b%b/%0d want 10/20", mem_en, mem_we, mem_addr);
        end
        cyc();
        smp();
        nvec++;
        if ({of_valid, of_err, st_gnt, of_rdata} !== {3'b101, 16'hBEEF}) begin
            errs++;
            $display("FAIL ind_n2: got v/e/stgnt/data %b%b%b/%h want 101/beef", of_valid, of_err, st_gnt, of_rdata);
        end
        ref_mem[100] = sd;
        cyc();
        st_req = 1'b0;
        cyc();
    endtask

    task automatic test_raw();
        host_write(10'd9, 16'h0011);
        st_req = 1'b1; st_addr = 10'd9; st_wdata = 16'h00AA;
        of_req = 1'b1; of_ind = 1'b0; of_addr = 10'd9;
        smp();
        nvec++;
        if ({st_gnt, of_gnt} !== 2'b10) begin
            errs++;
            $display("FAIL raw_n: got st/of gnt %b want 10", {st_gnt, of_gnt});
        end
        ref_mem[9] = 16'h00AA;
        cyc();
        st_req = 1'b0;
        smp();
        nvec++;
        if ({st_gnt, of_gnt} !== 2'b01) begin
            errs++;
            $display("FAIL raw_n1: got st/of gnt %b want 01", {st_gnt, of_gnt});
        end
        cyc();
        of_req = 1'b0;
        smp();
        nvec++;
        if ({of_valid, of_rdata} !== {1'b1, 16'h00AA}) begin
            errs++;
            $display("FAIL raw_n2: got v/data %b/%h want 1/00aa", of_valid, of_rdata);
        end
        cyc();
    endtask

    // Host starved by continuous stores: grants at 9, 18, 27; then pending store, then fetch.
    task automatic test_host_starve();
        bit exp_hs, exp_st, exp_of, exp_hv, exp_ov;
        bit st_new;
        st_new = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            hs_req = (k <= 27); hs_we = 1'b0; hs_addr = 10'd200;
            st_req = (k <= 28);
            of_req = (k >= 19 && k <= 29); of_ind = 1'b0; of_addr = 10'd202;
            if (st_new) begin
                st_addr = 10'd201; st_wdata = 16'($urandom); st_new = 1'b0;
            end
            smp();
            exp_hs = (k == 9 || k == 18 || k == 27);
            exp_st = (k <= 28) && !exp_hs;
            exp_of = (k == 29);
            exp_hv = (k == 10 || k == 19 || k == 28);
            exp_ov = (k == 30);
            nvec++;
            if ({st_gnt, of_gnt, hs_gnt, hs_valid, of_valid} !== {exp_st, exp_of, exp_hs, exp_hv, exp_ov}) begin
                errs++;
                $display("FAIL starve_k%0d: got st/of/hs gnt,hv,ov %b want %b", k,
                         {st_gnt, of_gnt, hs_gnt, hs_valid, of_valid}, {exp_st, exp_of, exp_hs, exp_hv, exp_ov});
            end
            if (exp_hv) begin
                nvec++;
                if (hs_rdata !== ref_mem[200]) begin
                    errs++;
                    $display("FAIL starve_hs_data: got %h want %h", hs_rdata, ref_mem[200]);
                end
            end
            if (exp_ov) begin
                nvec++;
                if (of_rdata !== ref_mem[202]) begin
                    errs++;
                    $display("FAIL starve_of_data: got %h want %h", of_rdata, ref_mem[202]);
                end
            end
            if (exp_st) begin
                ref_mem[201] = st_wdata;
                st_new = 1'b1;
            end
            cyc();
        end
        st_req = 1'b0; hs_req = 1'b0; of_req = 1'b0;
        cyc();
    endtask

    task automatic test_oor();
        of_req = 1'b1; of_ind = 1'b0; of_addr = 10'd700;
        smp();
        nvec++;
        if ({of_gnt, mem_en} !== 2'b10) begin
            errs++;
            $display("FAIL oor_of_n: got gnt/en %b want 10", {of_gnt, mem_en});
        end
        cyc();
        of_req = 1'b0;
        smp();
        nvec++;
        if ({of_valid, of_err, of_rdata} !== {2'b11, 16'h0}) begin
            errs++;
            $display("FAIL oor_of_resp: got v/e/data %b%b/%h want 11/0000", of_valid, of_err, of_rdata);
        end
        cyc();
        host_write(10'd3, 16'd650);
        of_req = 1'b1; of_ind = 1'b1; of_addr = 10'd3;
        wait_gnt(1, "oor_ind_gnt");
        cyc();
        of_req = 1'b0; of_ind = 1'b0;
        smp();
        nvec++;
        if ({mem_en, of_valid} !== 2'b00) begin
            errs++;
            $display("FAIL oor_ptr_n1: got en/valid %b want 00", {mem_en, of_valid});
        end
        cyc();
        smp();
        nvec++;
        if ({of_valid, of_err, of_rdata} !== {2'b11, 16'h0}) begin
            errs++;
            $display("FAIL oor_ptr_n2: got v/e/data %b%b/%h want 11/0000", of_valid, of_err, of_rdata);
        end
        cyc();
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = 10'd700; hs_wdata = 16'hDEAD;
        smp();
        nvec++;
        if ({hs_gnt, mem_en, mem_we} !== 3'b100) begin
            errs++;
            $display("FAIL oor_hs_wr: got gnt/en/we %b want 100", {hs_gnt, mem_en, mem_we});
        end
        cyc();
        hs_we = 1'b0; hs_addr = 10'd650;
        smp();
        nvec++;
        if ({hs_valid, hs_gnt, mem_en} !== 3'b010) begin
            errs++;
            $display("FAIL oor_hs_rd: got valid/gnt/en %b want 010", {hs_valid, hs_gnt, mem_en});
        end
        cyc();
        hs_req = 1'b0;
        smp();
        nvec++;
        if ({hs_valid, hs_rdata} !== {1'b1, 16'h0}) begin
            errs++;
            $display("FAIL oor_hs_resp: got v/data %b/%h want 1/0000", hs_valid, hs_rdata);
        end
        cyc();
    endtask

    task automatic test_reset_ind2();
        of_req = 1'b1; of_ind = 1'b1; of_addr = 10'd7;
        wait_gnt(1, "rst_ind_gnt");
        cyc();
        of_req = 1'b0; of_ind = 1'b0;
        #2 rst = 1'b0;
        #1;
        nvec++;
        if ({of_gnt, of_valid, of_err, st_gnt, hs_gnt, hs_valid, mem_en, mem_we, stall, mem_addr} !== '0) begin
            errs++;
            $display("FAIL rst_in_ind2: got %b want 0", {of_gnt, of_valid, of_err, st_gnt, hs_gnt, hs_valid, mem_en, mem_we, stall});
        end
        smp();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            nvec++;
            if ({of_valid, stall} !== 2'b00) begin
                errs++;
                $display("FAIL rst_stray_%0d: got valid/stall %b want 00", i, {of_valid, stall});
            end
        end
        cyc();
        direct_fetch(10'd20, "post_rst_fetch");
    endtask

    // Random traffic against a spec-level model: priority rule, wait count, memory contents.
    task automatic test_random();
        bit gst, gof, ghs, ind2, pbad, of_due, hs_due, oerr;
        logic [AW-1:0] pptr;
        logic [DW-1:0] oexp, hexp, tmp;
        int mcnt, sel;
        gst = 0; gof = 0; ghs = 0; ind2 = 0; pbad = 0; of_due = 0; hs_due = 0; oerr = 0;
        pptr = '0; oexp = '0; hexp = '0; mcnt = 0;
        for (int k = 0; k < 600; k++) begin
            cyc();
            if (gst) st_req = 1'b0;
            if (gof) of_req = 1'b0;
            if (ghs) hs_req = 1'b0;
            if (!st_req && $urandom_range(0, 99) < 30) begin
                st_req = 1'b1; st_addr = raddr(); st_wdata = 16'($urandom);
            end
            if (!of_req && $urandom_range(0, 99) < 40) begin
                of_req = 1'b1; of_addr = raddr(); of_ind = ($urandom_range(0, 9) < 3);
            end
            if (!hs_req && $urandom_range(0, 99) < 30) begin
                hs_req = 1'b1; hs_addr = raddr(); hs_we = 1'($urandom_range(0, 1)); hs_wdata = 16'($urandom);
            end
            smp();
            if (ind2)                                    sel = 0;
            else if (hs_req && mcnt == int'(HOST_MAXWAIT)) sel = 3;
            else if (st_req)                             sel = 1;
            else if (of_req)                             sel = 2;
            else if (hs_req)                             sel = 3;
            else                                         sel = 0;
            nvec++;
            if ({st_gnt, of_gnt, hs_gnt} !== {sel == 1, sel == 2, sel == 3}) begin
                errs++;
                $display("FAIL rnd_gnt c%0d: got st/of/hs %b want %b", k, {st_gnt, of_gnt, hs_gnt}, {sel == 1, sel == 2, sel == 3});
            end
            nvec++;
            if ({of_valid, of_err, of_rdata} !== {of_due, of_due & oerr, of_due ? oexp : 16'h0}) begin
                errs++;
                $display("FAIL rnd_of c%0d: got v/e/data %b%b/%h want %b%b/%h", k, of_valid, of_err, of_rdata, of_due, of_due & oerr, oexp);
            end
            nvec++;
            if ({hs_valid, hs_valid ? hs_rdata : 16'h0} !== {hs_due, hs_due ? hexp : 16'h0}) begin
                errs++;
                $display("FAIL rnd_hs c%0d: got v/data %b/%h want %b/%h", k, hs_valid, hs_rdata, hs_due, hexp);
            end
            nvec++;
            if (stall !== ((of_req && sel != 2) || ind2 || of_due)) begin
                errs++;
                $display("FAIL rnd_stall c%0d: got %b want %b", k, stall, (of_req && sel != 2) || ind2 || of_due);
            end
            of_due = 0; hs_due = 0;
            if (ind2) begin
                ind2 = 0; of_due = 1;
                oerr = pbad || !inr(pptr);
                oexp = oerr ? 16'h0 : ref_mem[pptr];
            end
            case (sel)
                1: if (inr(st_addr)) ref_mem[st_addr] = st_wdata;
                2: begin
                    if (of_ind) begin
                        ind2 = 1; pbad = !inr(of_addr);
                        tmp  = pbad ? 16'h0 : ref_mem[of_addr];
                        pptr = tmp[AW-1:0];
                    end else begin
                        of_due = 1; oerr = !inr(of_addr);
                        oexp = oerr ? 16'h0 : ref_mem[of_addr];
                    end
                end
                3: begin
                    if (hs_we) begin
                        if (inr(hs_addr)) ref_mem[hs_addr] = hs_wdata;
                    end else begin
                        hs_due = 1;
                        hexp = inr(hs_addr) ? ref_mem[hs_addr] : 16'h0;
                    end
                end
                default: ;
            endcase
            if (hs_req && sel != 3) mcnt = (mcnt < int'(HOST_MAXWAIT)) ? mcnt + 1 : int'(HOST_MAXWAIT);
            else                    mcnt = 0;
            gst = (sel == 1); gof = (sel == 2); ghs = (sel == 3);
        end
        cyc();
        st_req = 1'b0; of_req = 1'b0; hs_req = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        for (int a = 0; a < int'(DEPTH); a++) host_write(AW'(a), 16'($urandom));
        test_direct();
        test_indirect();
        test_raw();
        test_host_starve();
        test_oor();
        test_reset_ind2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
